// File: rtl/ddr_stream_fetch_if.sv
// Avalon-MM burst read bus between ddr_stream_fetch (master) and the DDR controller (slave).
interface ddr_stream_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_read;
  logic [6:0]            avm_burstcount;
  logic                  avm_waitrequest;
  logic [63:0]           avm_readdata;
  logic                  avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_burstcount,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_burstcount,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/ddr_stream_fetch.sv
// Credit-limited Avalon-MM burst reader that streams a wrapping DDR region into the
// layer's 64-bit DDR FIFO, requesting only while the FIFO reports almost-empty.
module ddr_stream_fetch #(
  parameter int          ADDR_WIDTH      = 32,
  parameter logic [63:0] BASE_ADDR       = 64'd0,
  parameter int          REGION_WORDS    = 84,
  parameter int          BURST_LEN       = 16,
  parameter int          MAX_OUTSTANDING = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable_i,
  input  logic               restart_i,
  input  logic               ddr_fifo_aempty,
  ddr_stream_fetch_if.master avm,
  output logic [63:0]        ddr_data,
  output logic               ddr_data_valid,
  output logic               busy_o
);
  localparam int IDX_W = $clog2(REGION_WORDS + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      word_idx_reg, word_idx_next;
  logic [OUT_W-1:0]      outstanding_reg, outstanding_next;
  logic                  rewind_reg, rewind_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [6:0]            burst_reg;
  logic                  read_reg;
  logic [63:0]           data_reg;
  logic                  valid_reg;
  logic                  busy_reg;

  logic [IDX_W-1:0]      start_idx;
  logic [31:0]           remaining;
  logic [31:0]           len_w;
  logic [31:0]           advanced;
  logic [6:0]            len;
  logic                  can_issue;
  logic                  accept;
  logic                  ret_dec;

  always_comb begin
    // A restart seen in IDLE takes effect on a burst issued in the same cycle.
    start_idx = restart_i ? '0 : word_idx_reg;
    remaining = 32'(REGION_WORDS) - 32'(start_idx);
    len_w     = (remaining < 32'(BURST_LEN)) ? remaining : 32'(BURST_LEN);
    len       = 7'(len_w);
    can_issue = enable_i && ddr_fifo_aempty &&
                ((32'(outstanding_reg) + len_w) <= 32'(MAX_OUTSTANDING));
    accept    = (state_reg == REQ) && !avm.avm_waitrequest;
    advanced  = 32'(word_idx_reg) + 32'(burst_reg);
    // A stray return with nothing outstanding is forwarded but never underflows the credit.
    ret_dec   = avm.avm_readdatavalid && (outstanding_reg != '0);

    outstanding_next = OUT_W'(32'(outstanding_reg)
                              + (accept  ? 32'(burst_reg) : 32'd0)
                              - (ret_dec ? 32'd1 : 32'd0));

    state_next    = state_reg;
    word_idx_next = word_idx_reg;
    rewind_next   = rewind_reg;
    case (state_reg)
      IDLE: begin
        word_idx_next = start_idx;
        if (can_issue) state_next = REQ;
      end
      REQ: begin
        // The request cannot be withdrawn, so a restart is remembered until accept.
        if (restart_i) rewind_next = 1'b1;
        if (accept) begin
          state_next  = IDLE;
          rewind_next = 1'b0;
          if (restart_i || rewind_reg || (advanced >= 32'(REGION_WORDS)))
            word_idx_next = '0;
          else
            word_idx_next = IDX_W'(advanced);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      word_idx_reg    <= '0;
      outstanding_reg <= '0;
      rewind_reg      <= 1'b0;
      addr_reg        <= ADDR_WIDTH'(BASE_ADDR);
      burst_reg       <= '0;
      read_reg        <= 1'b0;
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      word_idx_reg    <= word_idx_next;
      outstanding_reg <= outstanding_next;
      rewind_reg      <= rewind_next;
      if ((state_reg == IDLE) && can_issue) begin
        addr_reg  <= ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(start_idx) << 3);
        burst_reg <= len;
      end
      read_reg  <= (state_next == REQ);
      if (avm.avm_readdatavalid) data_reg <= avm.avm_readdata;
      valid_reg <= avm.avm_readdatavalid;
      busy_reg  <= (outstanding_next != '0) || (state_next == REQ);
    end
  end

  assign avm.avm_address    = addr_reg;
  assign avm.avm_read       = read_reg;
  assign avm.avm_burstcount = burst_reg;
  assign ddr_data           = data_reg;
  assign ddr_data_valid     = valid_reg;
  assign busy_o             = busy_reg;

endmodule

// File: tb/tb_ddr_stream_fetch.sv
// Scoreboard bench for ddr_stream_fetch: an Avalon slave model with a region-level
// reference of expected bursts and words, plus directed and randomized phases.
`timescale 1ns/1ps
module tb_ddr_stream_fetch;
  localparam int          ADDR_WIDTH      = 32;
  localparam logic [63:0] BASE_ADDR       = 64'h0;
  localparam int          REGION_WORDS    = 84;
  localparam int          BURST_LEN       = 16;
  localparam int          MAX_OUTSTANDING = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_i = 1'b0;
  logic        restart_i = 1'b0;
  logic        ddr_fifo_aempty = 1'b0;
  logic [63:0] ddr_data;
  logic        ddr_data_valid;
  logic        busy_o;

  ddr_stream_fetch_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  ddr_stream_fetch #(
    .ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .REGION_WORDS(REGION_WORDS),
    .BURST_LEN(BURST_LEN), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .restart_i(restart_i),
    .ddr_fifo_aempty(ddr_fifo_aempty), .avm(bus.master),
    .ddr_data(ddr_data), .ddr_data_valid(ddr_data_valid), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory contents as a function of the 64-bit word index.
  function automatic logic [63:0] mem_word(input int idx);
    return {32'hC0DE_0000 + 32'(idx), (~32'(idx)) ^ 32'h5A5A_1234};
  endfunction

  typedef struct { logic [63:0] data; int ready; } ret_t;
  ret_t        ret_q[$];
  logic [63:0] exp_q[$];
  int          acc_addr_q[$];
  int          acc_len_q[$];

  int  cyc = 0;
  int  model_idx = 0;
  bit  model_rewind = 0;
  int  acc_words = 0;
  int  ret_words = 0;
  int  accepts = 0;
  int  stall_left = 0;
  int  stalled_cycles = 0;
  int  latency = 3;
  bit  rand_wait = 0;
  bit  rand_gaps = 0;
  bit  hold_data = 0;
  bit  prev_stalled = 0;
  logic [ADDR_WIDTH-1:0] prev_addr;
  logic [6:0]            prev_len;

  // Avalon slave plus reference model; runs on the falling edge, DUT samples on the rising.
  always @(negedge clk) begin
    bit w;
    int exp_len;
    int a_idx;
    cyc++;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = {$urandom, $urandom};
    if (!reset_n) begin
      ret_q.delete();
      model_idx = 0; model_rewind = 0; acc_words = 0; ret_words = 0; prev_stalled = 0;
      bus.avm_waitrequest = 1'b0;
    end else begin
      if (restart_i) begin
        if (bus.avm_read) model_rewind = 1;
        else model_idx = 0;
      end
      w = 0;
      if (bus.avm_read && stall_left > 0) begin
        w = 1; stall_left--; stalled_cycles++;
      end else if (rand_wait) begin
        w = ($urandom_range(0, 2) == 0);
      end
      bus.avm_waitrequest = w;
      if (bus.avm_read && prev_stalled) begin
        check("addr_stable", 64'(bus.avm_address), 64'(prev_addr));
        check("len_stable", 64'(bus.avm_burstcount), 64'(prev_len));
      end
      prev_stalled = bus.avm_read && w;
      prev_addr    = bus.avm_address;
      prev_len     = bus.avm_burstcount;
      if (bus.avm_read && !w) begin
        exp_len = (REGION_WORDS - model_idx < BURST_LEN) ? REGION_WORDS - model_idx : BURST_LEN;
        check("burst_addr", 64'(bus.avm_address), BASE_ADDR + 64'(8 * model_idx));
        check("burst_len", 64'(bus.avm_burstcount), 64'(exp_len));
        check("credit", 64'(acc_words - ret_words + exp_len <= MAX_OUTSTANDING), 64'd1);
        for (int k = 0; k < exp_len; k++) exp_q.push_back(mem_word(model_idx + k));
        a_idx = int'((bus.avm_address - ADDR_WIDTH'(BASE_ADDR)) >> 3);
        for (int k = 0; k < int'(bus.avm_burstcount); k++)
          ret_q.push_back('{mem_word(a_idx + k), cyc + latency + k});
        acc_words += exp_len;
        accepts++;
        acc_addr_q.push_back(int'(bus.avm_address));
        acc_len_q.push_back(int'(bus.avm_burstcount));
        $display("burst %0d addr=0x%0h len=%0d", accepts, bus.avm_address, bus.avm_burstcount);
        model_idx    = model_rewind ? 0 : (model_idx + exp_len) % REGION_WORDS;
        model_rewind = 0;
      end
      if (!hold_data && ret_q.size() > 0 && ret_q[0].ready <= cyc &&
          !(rand_gaps && $urandom_range(0, 3) == 0)) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = ret_q[0].data;
        void'(ret_q.pop_front());
        ret_words++;
      end
    end
  end

  // Monitor: every forwarded word must be the next expected region word.
  always @(negedge clk) begin
    logic [63:0] exp_w;
    if (ddr_data_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_word actual=0x%0h required=none", ddr_data);
      end else begin
        exp_w = exp_q.pop_front();
        check("ddr_data", ddr_data, exp_w);
      end
    end
    if (!reset_n) exp_q.delete();
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
  endtask

  task automatic wait_accepts(input int target, input int budget, input string name);
    int n = 0;
    while (accepts < target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 64'(accepts >= target), 64'd1);
  endtask

  task automatic quiesce();
    int n = 0;
    enable_i = 1'b0;
    while ((bus.avm_read || busy_o || ret_q.size() > 0 || exp_q.size() > 0) && n < 800) begin
      tick(1);
      n++;
    end
    check("drain_busy", 64'(busy_o), 64'd0);
    check("drain_exp", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int a0;
    int s0;
    int n;
    int exp_addr[7] = '{0, 128, 256, 384, 512, 640, 0};
    int exp_lens[7] = '{16, 16, 16, 16, 16, 4, 16};

    tick(3);
    check("rst_read", 64'(bus.avm_read), 64'd0);
    check("rst_addr", 64'(bus.avm_address), BASE_ADDR);
    check("rst_len", 64'(bus.avm_burstcount), 64'd0);
    check("rst_data", ddr_data, 64'd0);
    check("rst_valid", 64'(ddr_data_valid), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // Basic region fetch.
    ddr_fifo_aempty = 1'b1;
    pulse_restart();
    a0 = accepts;
    enable_i = 1'b1;
    wait_accepts(a0 + 7, 400, "basic_timeout");
    for (int i = 0; i < 7; i++) begin
      if (a0 + i < acc_addr_q.size()) begin
        check("basic_addr", 64'(acc_addr_q[a0 + i]), 64'(exp_addr[i]));
        check("basic_len", 64'(acc_len_q[a0 + i]), 64'(exp_lens[i]));
      end
    end
    quiesce();

    // Credit limit with all data held back by the slave.
    pulse_restart();
    a0 = accepts;
    hold_data = 1;
    enable_i = 1'b1;
    tick(40);
    check("credit_bursts", 64'(accepts - a0), 64'd2);
    check("credit_read_low", 64'(bus.avm_read), 64'd0);
    check("credit_busy", 64'(busy_o), 64'd1);
    hold_data = 0;
    wait_accepts(a0 + 3, 60, "credit_third");
    quiesce();

    // Waitrequest stall of 5 cycles on a single burst.
    a0 = accepts;
    s0 = stalled_cycles;
    stall_left = 5;
    enable_i = 1'b1;
    n = 0;
    while (!bus.avm_read && n < 20) begin tick(1); n++; end
    enable_i = 1'b0;
    tick(15);
    check("stall_accepts", 64'(accepts - a0), 64'd1);
    check("stall_cycles", 64'(stalled_cycles - s0), 64'd5);
    quiesce();

    // Restart while stalled on the third burst (address 256).
    pulse_restart();
    a0 = accepts;
    enable_i = 1'b1;
    wait_accepts(a0 + 2, 100, "rq_first_two");
    s0 = stalled_cycles;
    stall_left = 8;
    n = 0;
    while (!(bus.avm_read && stalled_cycles > s0) && n < 100) begin tick(1); n++; end
    pulse_restart();
    wait_accepts(a0 + 4, 200, "rq_timeout");
    if (a0 + 3 < acc_addr_q.size()) begin
      check("rq_stalled_addr", 64'(acc_addr_q[a0 + 2]), 64'd256);
      check("rq_next_addr", 64'(acc_addr_q[a0 + 3]), 64'd0);
    end
    quiesce();

    // Almost-empty gating.
    ddr_fifo_aempty = 1'b0;
    enable_i = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.avm_read) n++;
    end
    check("gate_no_read", 64'(n), 64'd0);
    ddr_fifo_aempty = 1'b1;
    tick(1);
    check("gate_read_k1", 64'(bus.avm_read), 64'd1);

    // Randomized traffic: stalls, gaps, gating, enable drops and restarts.
    rand_wait = 1;
    rand_gaps = 1;
    for (int i = 0; i < 1500; i++) begin
      ddr_fifo_aempty = ($urandom_range(0, 3) != 0);
      enable_i        = ($urandom_range(0, 15) != 0);
      restart_i       = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    restart_i = 1'b0;
    quiesce();

    // Reset in the middle of returning data.
    rand_wait = 0;
    rand_gaps = 0;
    ddr_fifo_aempty = 1'b1;
    enable_i = 1'b1;
    n = 0;
    while (!ddr_data_valid && n < 100) begin tick(1); n++; end
    check("mid_valid_seen", 64'(ddr_data_valid), 64'd1);
    reset_n = 1'b0;
    tick(1);
    check("mid_rst_read", 64'(bus.avm_read), 64'd0);
    check("mid_rst_addr", 64'(bus.avm_address), BASE_ADDR);
    check("mid_rst_len", 64'(bus.avm_burstcount), 64'd0);
    check("mid_rst_data", ddr_data, 64'd0);
    check("mid_rst_valid", 64'(ddr_data_valid), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    enable_i = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    a0 = accepts;
    enable_i = 1'b1;
    wait_accepts(a0 + 1, 20, "post_rst_burst");
    if (a0 < acc_addr_q.size()) check("post_rst_addr", 64'(acc_addr_q[a0]), 64'd0);
    quiesce();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_stream_fetch.md
# ddr_stream_fetch

Avalon-MM burst read master that supplies the 64-bit DDR-side input of a convolution/deconvolution layer (`ddr_data` / `ddr_data_valid`). It fetches a linear region of DDR (coefficients or feature-map lines) in bursts, and issues requests only while the layer reports `ddr_fifo_aempty`. Outstanding reads are credit-limited so the layer's DDR FIFO can never overflow. The region wraps to its base address, so the same data is streamed every frame.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: Avalon byte address width.
- `BASE_ADDR`, 0: byte address of region start; must be 8-byte aligned.
- `REGION_WORDS`, 84: region length in 64-bit words (224*3/8); must be ≥1.
- `BURST_LEN`, 16: maximum words per burst; power of 2, ≤64.
- `MAX_OUTSTANDING`, 32: maximum words requested but not yet returned; must be ≥ `BURST_LEN`.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `enable_i` in 1: fetch enable; when low, no new bursts are issued.
- `restart_i` in 1: single-cycle pulse; rewinds the address to `BASE_ADDR`.
- `ddr_fifo_aempty` in 1: layer FIFO is below half-full; this is the request gate.
- `avm_address` out `ADDR_WIDTH`: burst start byte address.
- `avm_read` out 1: read request.
- `avm_burstcount` out 7: words in this burst.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdata` in 64: returned data.
- `avm_readdatavalid` in 1: returned data valid.
- `ddr_data` out 64: word to the layer FIFO.
- `ddr_data_valid` out 1: write strobe into the layer FIFO.
- `busy_o` out 1: high while the outstanding count is ≠0 or a request is pending.

## Operation
- State machine states: IDLE, REQ.
- IDLE → REQ when all of the following hold: `enable_i`=1, `ddr_fifo_aempty`=1, and `outstanding + len ≤ MAX_OUTSTANDING`.
  - `len = min(BURST_LEN, REGION_WORDS - word_idx)`.
  - On this transition, `avm_address = BASE_ADDR + 8*word_idx` and `avm_burstcount = len` are registered.
- In REQ, `avm_read`=1 and address/burstcount are held stable until a cycle with `avm_waitrequest`=0 (accept).
  - On accept: `outstanding += len`, `word_idx += len`.
  - If `word_idx` reaches `REGION_WORDS`, it wraps to 0.
  - Then return to IDLE.
- Bursts never cross the region end; the last burst of the region is short when `REGION_WORDS` is not a multiple of `BURST_LEN`.
- Minimum gap between bursts: one IDLE cycle.
- Each `avm_readdatavalid`=1 cycle: `outstanding -= 1`, and the word is forwarded.
  - Accept and a returning word in the same cycle: net `outstanding += len-1`.
- `outstanding` width is `$clog2(MAX_OUTSTANDING+1)`; it never exceeds `MAX_OUTSTANDING` and never underflows.
  - A `readdatavalid` while `outstanding`=0 is a slave protocol error; the counter stays at 0 and the word is still forwarded.
- `restart_i` in IDLE: `word_idx` ← 0 immediately.
- `restart_i` in REQ: the pending request is held until accepted (Avalon rules forbid withdrawing it). `word_idx` ← 0 at accept instead of advancing.
- In-flight words are always forwarded; they are never dropped.
- `enable_i` falling: the current REQ completes; no further bursts are issued; returning data is still forwarded.
- `ddr_fifo_aempty` is sampled only in IDLE. Dropping it during REQ does not cancel the request.

## Timing
- Reset values:
  - Outputs: `avm_read`=0, `avm_address`=`BASE_ADDR`, `avm_burstcount`=0, `ddr_data`=0, `ddr_data_valid`=0, `busy_o`=0.
  - Internal: state=IDLE, `word_idx`=0, `outstanding`=0.
- Reset mid-burst:
  - Everything returns to the values above within one clock.
  - Read data returned after reset is forwarded, but `outstanding` is not decremented below 0.
  - The integration must reset the slave at the same time.
- Request latency: condition true in cycle N → `avm_read`=1 in cycle N+1.
- Data path: `avm_readdatavalid`/`avm_readdata` at edge N → `ddr_data_valid`/`ddr_data` at edge N+1. Fixed 1-cycle latency, registered.
- Back-to-back return: one word per clock with no bubbles inserted.
- All outputs are registered.

## Test plan
- **Basic region fetch:** `REGION_WORDS`=84, `BURST_LEN`=16, aempty held at 1, slave with zero waitrequest and 3-cycle latency → 6 bursts of 16,16,16,16,16,4 at byte addresses 0,128,256,384,512,640. Next burst at address 0. `ddr_data` order matches memory.
- **Credit limit:** `MAX_OUTSTANDING`=32, slave holds all data → exactly 2 bursts accepted, `avm_read` stays 0. After 16 words return, a third burst issues.
- **Waitrequest stall:** waitrequest=1 for 5 cycles → address and burstcount stable throughout; exactly one accept; `outstanding` increments once by 16.
- **Restart during REQ:** `restart_i` while stalled at address 256 → that burst is accepted; the next burst is at address 0; all 16 returned words of the stalled burst appear on `ddr_data`.
- **Aempty gating:** aempty=0 → no `avm_read` for 100 cycles. aempty rises at cycle K → `avm_read`=1 at K+1.
- **Simultaneous accept and return:** `outstanding`=5, accept of 16 coincides with readdatavalid → `outstanding`=20. Reset asserted mid-return → all outputs return to reset values on the next clock.
